chart_recorder: RTL and testbench

Records live play into a 4-lane chart memory, the write side of the chart ROM that the game controller plays back. While recording, it samples the four lane keys, collapses key presses into one 4-bit row per chart row period, and writes rows sequentially into a 4-bit-wide chart RAM. The write timing is tied to the playback timing, so a recorded chart replays at the same rate.

---
 rtl/chart_recorder_pkg.sv | 16 +
 rtl/chart_recorder_key_edge.sv | 34 +++
 rtl/chart_recorder.sv | 158 +++++++++++++++
 tb/tb_chart_recorder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chart_recorder_pkg.sv
// Shared definitions for the chart recorder and the playback controller,
// so record and replay rates come from one place.
package chart_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } rec_state_e;

  localparam int DEF_TICK_DIV  = 200000;
  localparam int DEF_ROW_STEPS = 140;
  localparam int LANES         = 4;

endpackage

// File: rtl/chart_recorder_key_edge.sv
// Two-flop synchronizer for one raw lane key plus a one-cycle press pulse.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Combinational so a press seen in the row-boundary cycle still lands in that row.
  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/chart_recorder.sv
// Records lane key presses into sequential 4-bit chart rows, one row per
// playback row period, and writes them to the chart RAM.
module chart_recorder
  import chart_recorder_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ROW_STEPS = DEF_ROW_STEPS,
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key0,
  input  logic              key1,
  input  logic              key2,
  input  logic              key3,
  input  logic              rec_start,
  input  logic              rec_stop,
  output logic              busy,
  output logic              full,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LANES-1:0]  wr_data,
  output logic [ADDR_W:0]   rows_written
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (ROW_STEPS > 1) ? $clog2(ROW_STEPS) : 1;

  logic [LANES-1:0] lane_keys;
  logic [LANES-1:0] lane_pulse;

  assign lane_keys = {key3, key2, key1, key0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    key_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .key   (lane_keys[i]),
      .pulse (lane_pulse[i])
    );
  end

  rec_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LANES-1:0]  acc_q, acc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LANES-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W:0]   rows_q, rows_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;

  logic             tick_last;
  logic             step_last;
  logic             row_boundary;
  logic             last_addr;
  logic [LANES-1:0] acc_now;

  assign tick_last    = (tick_q == TICK_W'(TICK_DIV - 1));
  assign step_last    = (step_q == STEP_W'(ROW_STEPS - 1));
  assign row_boundary = tick_last && step_last;
  assign last_addr    = (rows_q == (ADDR_W + 1)'(DEPTH - 1));
  assign acc_now      = acc_q | lane_pulse;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    step_d    = step_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rows_d    = rows_q;
    full_d    = full_q;

    case (state_q)
      IDLE, DONE: begin
        if (rec_start) begin
          state_d   = RECORD;
          tick_d    = '0;
          step_d    = '0;
          acc_d     = '0;
          wr_addr_d = '0;
          rows_d    = '0;
          full_d    = 1'b0;
        end
      end

      RECORD: begin
        if (tick_last) begin
          tick_d = '0;
          step_d = step_last ? '0 : step_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        acc_d = acc_now;

        // The stop row is written at once, so wr_en shows up during FLUSH.
        if (row_boundary || rec_stop) begin
          wr_en_d   = 1'b1;
          wr_data_d = acc_now;
          wr_addr_d = rows_q[ADDR_W-1:0];
          rows_d    = rows_q + 1'b1;
          acc_d     = '0;
          if (last_addr) begin
            state_d = DONE;
            full_d  = 1'b1;
          end else if (row_boundary) begin
            state_d = rec_stop ? DONE : RECORD;
          end else begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RECORD) || (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rows_q    <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rows_q    <= rows_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign full         = full_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rows_written = rows_q;

endmodule

// File: tb/tb_chart_recorder.sv
// Bench for chart_recorder: a cycle table, hand-written corner sequences and a
// random phase, all also watched against a row-window reference model.
module tb_chart_recorder;

  localparam int TD  = 4;
  localparam int RS  = 2;
  localparam int AW  = 2;
  localparam int DP  = 4;
  localparam int WIN = TD * RS;

  localparam int M_IDLE = 0;
  localparam int M_REC  = 1;
  localparam int M_FLSH = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    keys;
  logic          rec_start;
  logic          rec_stop;
  logic          busy;
  logic          full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [AW:0]   rows_written;

  int vectors     = 0;
  int miscompares = 0;

  chart_recorder #(
    .TICK_DIV  (TD),
    .ROW_STEPS (RS),
    .ADDR_W    (AW),
    .DEPTH     (DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key0         (keys[0]),
    .key1         (keys[1]),
    .key2         (keys[2]),
    .key3         (keys[3]),
    .rec_start    (rec_start),
    .rec_stop     (rec_stop),
    .busy         (busy),
    .full         (full),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rows_written (rows_written)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic s, input logic p);
    keys      = k;
    rec_start = s;
    rec_stop  = p;
    stepCycle();
    rec_start = 1'b0;
    rec_stop  = 1'b0;
  endtask

  // Reference model: a press counts two edges after the key is first sampled
  // high; rows close every WIN cycles of recording or on stop.
  int         m_mode = M_IDLE;
  int         m_pos  = 0;
  int         m_rows = 0;
  logic       m_full = 1'b0;
  logic [3:0] m_acc  = 4'b0;
  logic [3:0] hist [3] = '{4'b0, 4'b0, 4'b0};
  logic       exp_wr_en = 1'b0;
  int         exp_addr  = 0;
  logic [3:0] exp_data  = 4'b0;

  always @(posedge clk) begin : model
    logic [3:0] press;
    logic       window_end;
    press   = hist[1] & ~hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = keys;
    exp_wr_en = 1'b0;
    if (rst) begin
      hist   = '{4'b0, 4'b0, 4'b0};
      m_mode = M_IDLE;
      m_pos  = 0;
      m_rows = 0;
      m_full = 1'b0;
      m_acc  = 4'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (rec_start) begin
            m_mode = M_REC;
            m_pos  = 0;
            m_rows = 0;
            m_full = 1'b0;
            m_acc  = 4'b0;
          end
        end
        M_REC: begin
          m_acc      = m_acc | press;
          window_end = (m_pos == WIN - 1);
          m_pos      = (m_pos + 1) % WIN;
          if (window_end || rec_stop) begin
            exp_wr_en = 1'b1;
            exp_addr  = m_rows;
            exp_data  = m_acc;
            m_rows    = m_rows + 1;
            m_acc     = 4'b0;
            if (m_rows == DP) begin
              m_full = 1'b1;
              m_mode = M_DONE;
            end else if (window_end) begin
              m_mode = rec_stop ? M_DONE : M_REC;
            end else begin
              m_mode = M_FLSH;
            end
          end
        end
        default: m_mode = M_DONE;
      endcase
    end
  end

  always @(negedge clk) begin : model_check
    logic [15:0] act;
    logic [15:0] expv;
    act  = {4'b0, wr_en, busy, full, rows_written,
            exp_wr_en ? wr_addr : 2'b0, exp_wr_en ? wr_data : 4'b0};
    expv = {4'b0, exp_wr_en, (m_mode == M_REC) || (m_mode == M_FLSH), m_full,
            3'(m_rows), exp_wr_en ? 2'(exp_addr) : 2'b0, exp_wr_en ? exp_data : 4'b0};
    checkOutput("model", act, expv);
  end

  typedef struct {
    int          n;
    logic [3:0]  k;
    logic        s;
    logic        p;
    logic        e_wr;
    logic [1:0]  e_addr;
    logic [3:0]  e_data;
    logic [2:0]  e_rows;
    logic        e_busy;
    logic        e_full;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int wr_count;
    int busy_count;
    int addr_q [$];

    tbl[0]  = '{1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{2, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{6, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 3'd1, 1'b1, 1'b0};
    tbl[3]  = '{2, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{2, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[5]  = '{1, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0100, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd2, 1'b0, 1'b0};
    tbl[7]  = '{3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 3'd2, 1'b0, 1'b0};
    tbl[8]  = '{1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{2, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{2, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[11] = '{2, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0};
    tbl[12] = '{2, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1001, 3'd1, 1'b1, 1'b0};

    rst       = 1'b1;
    keys      = 4'b0;
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset_outputs", {4'b0, busy, full, wr_en, wr_addr, wr_data, rows_written}, 16'h0);
    rst = 1'b0;

    // Single press, stop mid-window (with a stray stop in DONE), restart, two lanes in one row.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].k, tbl[i].s, tbl[i].p);
      for (int c = 1; c < tbl[i].n; c++) applyStimulus(tbl[i].k, 1'b0, 1'b0);
      checkOutput($sformatf("tbl%0d_ctrl", i), {10'b0, wr_en, busy, full, rows_written},
                  {10'b0, tbl[i].e_wr, tbl[i].e_busy, tbl[i].e_full, tbl[i].e_rows});
      if (tbl[i].e_wr)
        checkOutput($sformatf("tbl%0d_write", i), {10'b0, wr_addr, wr_data},
                    {10'b0, tbl[i].e_addr, tbl[i].e_data});
    end

    // Stop in the boundary cycle of window 1: one boundary write, no flush row.
    for (int c = 0; c < WIN - 1; c++) applyStimulus(4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0, 1'b0, 1'b1);
    checkOutput("stop_boundary_write", {8'b0, wr_en, busy, full, wr_addr, rows_written},
                {8'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2});
    wr_count = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'b0, 1'b0, 1'b0);
      if (wr_en) wr_count++;
    end
    checkOutput("stop_boundary_no_flush", 16'(wr_count), 16'd0);

    // Record without stopping until memory fills.
    applyStimulus(4'b0, 1'b1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(4'b0, 1'b0, 1'b0);
      if (wr_en) addr_q.push_back(int'(wr_addr));
    end
    checkOutput("full_write_count", 16'(addr_q.size()), 16'd4);
    for (int a = 0; a < addr_q.size() && a < DP; a++)
      checkOutput($sformatf("full_addr%0d", a), 16'(addr_q[a]), 16'(a));
    checkOutput("full_state", {11'b0, busy, full, rows_written}, {11'b0, 1'b0, 1'b1, 3'd4});

    applyStimulus(4'b0, 1'b1, 1'b0);
    checkOutput("restart_clears_full", {11'b0, busy, full, rows_written}, {11'b0, 1'b1, 1'b0, 3'd0});
    for (int c = 0; c < WIN; c++) applyStimulus(4'b0, 1'b0, 1'b0);
    checkOutput("restart_first_write", {9'b0, wr_en, full, wr_addr, rows_written},
                {9'b0, 1'b1, 1'b0, 2'd0, 3'd1});

    // Reset in the middle of a recording, then a stray stop.
    for (int c = 0; c < 3; c++) applyStimulus(4'b0, 1'b0, 1'b0);
    rst = 1'b1;
    stepCycle();
    checkOutput("reset_mid_outputs", {4'b0, busy, full, wr_en, wr_addr, wr_data, rows_written}, 16'h0);
    rst = 1'b0;
    applyStimulus(4'b0, 1'b0, 1'b1);
    wr_count   = 0;
    busy_count = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0, 1'b0, 1'b0);
      if (wr_en) wr_count++;
      if (busy) busy_count++;
    end
    checkOutput("reset_mid_no_writes", 16'(wr_count), 16'd0);
    checkOutput("reset_mid_idle", {12'b0, 1'(busy_count != 0), rows_written}, 16'h0);

    // Random keys, starts, stops and occasional resets against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] k;
      k = keys;
      for (int l = 0; l < 4; l++)
        if ($urandom_range(5) == 0) k[l] = ~k[l];
      if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        applyStimulus(k, 1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        applyStimulus(k, $urandom_range(39) == 0, $urandom_range(49) == 0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
